// File: rtl/interrupt_controller.sv
// 8051 interrupt arbiter: latches the five standard sources, resolves IE/IP priority,
// drives the vectored request to program_counter and tracks two-level in-service state.
module interrupt_controller #(
   parameter logic [7:0] VEC_BASE = 8'h03
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [7:0] ie_i,
   input  logic [7:0] ip_i,
   input  logic       it0_i,
   input  logic       it1_i,
   input  logic       int0_n_i,
   input  logic       int1_n_i,
   input  logic       tf0_i,
   input  logic       tf1_i,
   input  logic       ri_i,
   input  logic       ti_i,
   input  logic       reti_i,
   input  logic       int_ack_i,
   output logic       int_o,
   output logic [7:0] int_vec_o,
   output logic       clr_tf0_o,
   output logic       clr_tf1_o,
   output logic       ie0_o,
   output logic       ie1_o,
   output logic [1:0] in_service_o
);

   typedef enum logic {IDLE, REQ} state_e;

   state_e     state_q, state_d;
   logic       int0_q, int1_q;
   logic       ie0_q, ie0_d, ie1_q, ie1_d;
   logic       int_q, int_d;
   logic [7:0] vec_q, vec_d;
   logic [2:0] src_q, src_d;
   logic       lvl_q, lvl_d;
   logic [1:0] inSvc_q, inSvc_d;
   logic       clrTf0_q, clrTf0_d, clrTf1_q, clrTf1_d;

   logic [4:0] pending, hiPend, loPend;
   logic [2:0] selIdx;
   logic       selLvl, selValid, eligible, ackTaken;
   logic [1:0] setMask, clrMask;
   logic       unusedBits;

   assign unusedBits = ^{ie_i[6:5], ip_i[7:5]};

   // Priority resolve: any high-level source beats all low-level ones, lowest index wins within a level
   always_comb begin
      pending  = {ri_i | ti_i, tf1_i, ie1_q, tf0_i, ie0_q} & ie_i[4:0] & {5{ie_i[7]}};
      hiPend   = pending & ip_i[4:0];
      loPend   = pending & ~ip_i[4:0];
      selIdx   = 3'd0;
      selLvl   = 1'b0;
      selValid = 1'b0;
      if (hiPend != 5'd0) begin
         selLvl   = 1'b1;
         selValid = 1'b1;
         for (int n = 4; n >= 0; n--) begin
            if (hiPend[n]) selIdx = 3'(n);
         end
      end else if (loPend != 5'd0) begin
         selValid = 1'b1;
         for (int n = 4; n >= 0; n--) begin
            if (loPend[n]) selIdx = 3'(n);
         end
      end
      eligible = selValid & (selLvl ? ~inSvc_q[1] : (inSvc_q == 2'b00));
   end

   always_comb begin
      state_d  = state_q;
      int_d    = int_q;
      vec_d    = vec_q;
      src_d    = src_q;
      lvl_d    = lvl_q;
      setMask  = 2'b00;
      ackTaken = 1'b0;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d = REQ;
               int_d   = 1'b1;
               vec_d   = VEC_BASE + {2'b00, selIdx, 3'b000};
               src_d   = selIdx;
               lvl_d   = selLvl;
            end
         end
         REQ: begin
            if (int_ack_i) begin
               state_d  = IDLE;
               int_d    = 1'b0;
               ackTaken = 1'b1;
               setMask  = lvl_q ? 2'b10 : 2'b01;
            end
         end
         default: state_d = IDLE;
      endcase

      // RETI retires the innermost level; the mask is taken from the pre-edge state
      clrMask = 2'b00;
      if (reti_i) clrMask = inSvc_q[1] ? 2'b10 : {1'b0, inSvc_q[0]};
      inSvc_d = (inSvc_q & ~clrMask) | setMask;

      if (it0_i) begin
         if (int0_q && !int0_n_i)           ie0_d = 1'b1;
         else if (ackTaken && src_q == 3'd0) ie0_d = 1'b0;
         else                               ie0_d = ie0_q;
      end else begin
         ie0_d = ~int0_n_i;
      end

      if (it1_i) begin
         if (int1_q && !int1_n_i)           ie1_d = 1'b1;
         else if (ackTaken && src_q == 3'd2) ie1_d = 1'b0;
         else                               ie1_d = ie1_q;
      end else begin
         ie1_d = ~int1_n_i;
      end

      clrTf0_d = ackTaken && (src_q == 3'd1);
      clrTf1_d = ackTaken && (src_q == 3'd3);
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         int0_q   <= 1'b1;
         int1_q   <= 1'b1;
         ie0_q    <= 1'b0;
         ie1_q    <= 1'b0;
         int_q    <= 1'b0;
         vec_q    <= 8'h00;
         src_q    <= 3'd0;
         lvl_q    <= 1'b0;
         inSvc_q  <= 2'b00;
         clrTf0_q <= 1'b0;
         clrTf1_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         int0_q   <= int0_n_i;
         int1_q   <= int1_n_i;
         ie0_q    <= ie0_d;
         ie1_q    <= ie1_d;
         int_q    <= int_d;
         vec_q    <= vec_d;
         src_q    <= src_d;
         lvl_q    <= lvl_d;
         inSvc_q  <= inSvc_d;
         clrTf0_q <= clrTf0_d;
         clrTf1_q <= clrTf1_d;
      end
   end

   assign int_o        = int_q;
   assign int_vec_o    = vec_q;
   assign clr_tf0_o    = clrTf0_q;
   assign clr_tf1_o    = clrTf1_q;
   assign ie0_o        = ie0_q;
   assign ie1_o        = ie1_q;
   assign in_service_o = inSvc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios plus randomized traffic,
// all checked against a behavioural model built on a stack of in-service levels.
module tb_interrupt_controller;

   logic       clock, reset;
   logic [7:0] ie, ip;
   logic       it0, it1, int0N, int1N, tf0, tf1, ri, ti, reti, intAck;
   logic       intReq, clrTf0, clrTf1, ie0, ie1;
   logic [7:0] intVec;
   logic [1:0] inService;

   int errorCount = 0;
   int checkCount = 0;

   // Reference model state
   logic       mInt, mIe0, mIe1, mPin0Prev, mPin1Prev, mClr0, mClr1;
   logic [7:0] mVec;
   int         mSrc, mLvl;
   int         svcStack[$];

   interrupt_controller #(.VEC_BASE(8'h03)) dut (
      .clock_i(clock), .reset_i(reset), .ie_i(ie), .ip_i(ip),
      .it0_i(it0), .it1_i(it1), .int0_n_i(int0N), .int1_n_i(int1N),
      .tf0_i(tf0), .tf1_i(tf1), .ri_i(ri), .ti_i(ti),
      .reti_i(reti), .int_ack_i(intAck),
      .int_o(intReq), .int_vec_o(intVec), .clr_tf0_o(clrTf0), .clr_tf1_o(clrTf1),
      .ie0_o(ie0), .ie1_o(ie1), .in_service_o(inService)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] stackBits();
      logic [1:0] b = 2'b00;
      foreach (svcStack[i]) b[svcStack[i]] = 1'b1;
      return b;
   endfunction

   task automatic modelReset();
      mInt = 0; mVec = 8'h00; mSrc = 0; mLvl = 0;
      mIe0 = 0; mIe1 = 0; mPin0Prev = 1; mPin1Prev = 1;
      mClr0 = 0; mClr1 = 0;
      svcStack.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic modelStep();
      logic ackTaken, nIe0, nIe1, found, hasHigh, eligible;
      logic [4:0] pend;
      int pickIdx, pickLvl;
      ackTaken = mInt && intAck;
      if (it0) nIe0 = (mPin0Prev && !int0N) ? 1'b1 : ((ackTaken && mSrc == 0) ? 1'b0 : mIe0);
      else     nIe0 = !int0N;
      if (it1) nIe1 = (mPin1Prev && !int1N) ? 1'b1 : ((ackTaken && mSrc == 2) ? 1'b0 : mIe1);
      else     nIe1 = !int1N;
      pend[0] = mIe0 && ie[0] && ie[7];
      pend[1] = tf0 && ie[1] && ie[7];
      pend[2] = mIe1 && ie[2] && ie[7];
      pend[3] = tf1 && ie[3] && ie[7];
      pend[4] = (ri || ti) && ie[4] && ie[7];
      found = 0; pickIdx = 0; pickLvl = 0;
      for (int lvl = 1; lvl >= 0; lvl--)
         for (int n = 0; n < 5; n++)
            if (!found && pend[n] && (int'(ip[n]) == lvl)) begin
               found = 1; pickIdx = n; pickLvl = lvl;
            end
      hasHigh = 0;
      foreach (svcStack[i]) if (svcStack[i] == 1) hasHigh = 1;
      eligible = found && ((pickLvl == 1) ? !hasHigh : (svcStack.size() == 0));
      if (reti && svcStack.size() > 0) void'(svcStack.pop_back());
      if (ackTaken) svcStack.push_back(mLvl);
      mClr0 = ackTaken && mSrc == 1;
      mClr1 = ackTaken && mSrc == 3;
      if (mInt) begin
         if (ackTaken) mInt = 0;
      end else if (eligible) begin
         mInt = 1;
         mVec = 8'h03 + 8'(8 * pickIdx);
         mSrc = pickIdx;
         mLvl = pickLvl;
      end
      mIe0 = nIe0; mIe1 = nIe1;
      mPin0Prev = int0N; mPin1Prev = int1N;
   endtask

   task automatic applyStimulus();
      modelStep();
      @(posedge clock);
      #1;
      checkOutput("int", intReq, mInt);
      if (mInt) checkOutput("intVec", intVec, mVec);
      checkOutput("ie0", ie0, mIe0);
      checkOutput("ie1", ie1, mIe1);
      checkOutput("inService", inService, stackBits());
      checkOutput("clrTf0", clrTf0, mClr0);
      checkOutput("clrTf1", clrTf1, mClr1);
   endtask

   task automatic idleInputs();
      ie = 8'h00; ip = 8'h00; it0 = 0; it1 = 0; int0N = 1; int1N = 1;
      tf0 = 0; tf1 = 0; ri = 0; ti = 0; reti = 0; intAck = 0;
   endtask

   task automatic doReset();
      idleInputs();
      reset = 0;
      #1;
      modelReset();
      @(posedge clock);
      #1;
      reset = 1;
   endtask

   initial begin
      idleInputs();
      modelReset();
      reset = 0;
      tf0 = 1;
      #2;
      checkOutput("rstInt", intReq, 0);
      checkOutput("rstVec", intVec, 8'h00);
      checkOutput("rstSvc", inService, 2'b00);
      checkOutput("rstIe0", ie0, 0);
      checkOutput("rstClr0", clrTf0, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1;
      ie = 8'h82;
      applyStimulus();
      checkOutput("t1Vec", intVec, 8'h0B);

      // Simultaneous external edges, INT0 wins, INT1 follows after RETI
      doReset();
      ie = 8'h85; it0 = 1; it1 = 1;
      applyStimulus();
      int0N = 0; int1N = 0;
      applyStimulus();
      checkOutput("t2Ie0", ie0, 1);
      checkOutput("t2Ie1", ie1, 1);
      applyStimulus();
      checkOutput("t2Vec0", intVec, 8'h03);
      int0N = 1; int1N = 1; intAck = 1;
      applyStimulus();
      checkOutput("t2Ie0Clr", ie0, 0);
      checkOutput("t2Svc", inService, 2'b01);
      intAck = 0; reti = 1;
      applyStimulus();
      reti = 0;
      applyStimulus();
      checkOutput("t2Vec1", intVec, 8'h13);

      // Nesting a high-level Timer0 inside low-level Timer1
      doReset();
      tf1 = 1; ie = 8'h88;
      applyStimulus();
      checkOutput("t3Vec1B", intVec, 8'h1B);
      intAck = 1;
      applyStimulus();
      intAck = 0; ie = 8'h8B; ip = 8'h02; tf0 = 1;
      applyStimulus();
      checkOutput("t3NestInt", intReq, 1);
      checkOutput("t3NestVec", intVec, 8'h0B);
      intAck = 1;
      applyStimulus();
      checkOutput("t3Svc11", inService, 2'b11);
      intAck = 0; tf0 = 0; tf1 = 0;
      applyStimulus();
      checkOutput("t3Quiet", intReq, 0);
      reti = 1;
      applyStimulus();
      checkOutput("t3Reti1", inService, 2'b01);
      applyStimulus();
      checkOutput("t3Reti0", inService, 2'b00);
      reti = 0;

      // Level-triggered INT0 survives acknowledge
      doReset();
      it0 = 0; int0N = 0; ie = 8'h81;
      applyStimulus();
      applyStimulus();
      checkOutput("t4Vec", intVec, 8'h03);
      intAck = 1;
      applyStimulus();
      checkOutput("t4Ie0", ie0, 1);
      checkOutput("t4Clr0", clrTf0, 0);
      intAck = 0;
      applyStimulus();
      reti = 1;
      applyStimulus();
      reti = 0;
      applyStimulus();
      checkOutput("t4ReInt", intReq, 1);
      checkOutput("t4ReVec", intVec, 8'h03);

      // Committed request is frozen against new sources and EA dropping
      doReset();
      ie = 8'h82; tf0 = 1;
      applyStimulus();
      tf1 = 1; ie = 8'h08;
      applyStimulus();
      checkOutput("t5Hold", intReq, 1);
      checkOutput("t5HoldVec", intVec, 8'h0B);
      intAck = 1;
      applyStimulus();
      checkOutput("t5Pulse", clrTf0, 1);
      intAck = 0; tf0 = 0;
      applyStimulus();
      checkOutput("t5PulseEnd", clrTf0, 0);

      // Asynchronous reset aborts a pending request
      doReset();
      ie = 8'h82; tf0 = 1;
      applyStimulus();
      #2;
      reset = 0;
      #1;
      checkOutput("t6AbortInt", intReq, 0);
      checkOutput("t6AbortSvc", inService, 2'b00);
      modelReset();
      ie = 8'h00; tf0 = 0; intAck = 1;
      #1;
      reset = 1;
      applyStimulus();
      checkOutput("t6LateAck", inService, 2'b00);
      intAck = 0;

      // Randomized traffic
      doReset();
      for (int c = 0; c < 800; c++) begin
         ie = {($urandom_range(0, 7) != 0), 2'b00, 5'($urandom)};
         ip = 8'($urandom) & 8'h1F;
         if ($urandom_range(0, 31) == 0) it0 = 1'($urandom);
         if ($urandom_range(0, 31) == 0) it1 = 1'($urandom);
         if ($urandom_range(0, 3) == 0) int0N = ~int0N;
         if ($urandom_range(0, 3) == 0) int1N = ~int1N;
         tf0 = ($urandom_range(0, 3) == 0);
         tf1 = ($urandom_range(0, 3) == 0);
         ri = ($urandom_range(0, 7) == 0);
         ti = ($urandom_range(0, 7) == 0);
         intAck = ($urandom_range(0, 2) == 0);
         reti = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
